// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed Booth multiplier and non-restoring divider sharing one datapath
module mul_div_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] Zhigh,
  output logic [31:0] Zlow
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        go, opr, sa, sb, qm1, accept;
  logic [32:0] acc, msx, bsum, mul_acc, sh, div_r;
  logic [31:0] q, m, mul_q, div_q, rem, quo, rmd;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign accept = start & ~go & (state != RUN);
  always_comb begin
    msx     = {m[31], m};
    bsum    = (q[0] & ~qm1) ? acc - msx : (~q[0] & qm1) ? acc + msx : acc;
    mul_acc = {bsum[32], bsum[32:1]};
    mul_q   = {bsum[0], q[31:1]};
    sh      = {acc[31:0], q[31]};
    div_r   = acc[32] ? sh + {1'b0, m} : sh - {1'b0, m};
    div_q   = {q[30:0], ~div_r[32]};
    rem     = div_r[32] ? div_r[31:0] + m : div_r[31:0];
    quo     = (sa ^ sb) ? -div_q : div_q;
    rmd     = sa ? -rem : rem;
  end
  // go marks the operand-load cycle between acceptance and RUN/DONE
  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= IDLE;
      cnt         <= '0;
      go          <= 1'b0;
      opr         <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      qm1         <= 1'b0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      div_by_zero <= 1'b0;
      Zhigh       <= '0;
      Zlow        <= '0;
    end else begin
      go <= accept;
      if (accept) begin
        state       <= IDLE;
        opr         <= op;
        sa          <= A[31];
        sb          <= B[31];
        acc         <= '0;
        qm1         <= 1'b0;
        cnt         <= '0;
        q           <= (op & A[31]) ? -A : A;
        m           <= (op & B[31]) ? -B : B;
        div_by_zero <= 1'b0;
      end else if (go) begin
        if (opr && m == '0) begin
          state       <= DONE;
          div_by_zero <= 1'b1;
          Zhigh       <= sa ? -q : q;
          Zlow        <= '1;
        end else begin
          state <= RUN;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        acc <= opr ? div_r : mul_acc;
        q   <= opr ? div_q : mul_q;
        qm1 <= q[0];
        if (cnt == 5'd31) begin
          state <= DONE;
          Zhigh <= opr ? rmd : mul_acc[31:0];
          Zlow  <= opr ? quo : mul_q;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized self-checking bench for mul_div_unit against a plain-arithmetic model
module tb_mul_div_unit;
  logic        clock, clear, start, op;
  logic [31:0] A, B;
  logic        busy, done, div_by_zero;
  logic [31:0] Zhigh, Zlow;
  int          checks, errors;
  logic [31:0] prev_hi, prev_lo;
  mul_div_unit dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .Zhigh(Zhigh), .Zlow(Zlow)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic void model(input bit o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint x, y, p, qt, r;
    x = $signed(a);
    y = $signed(b);
    dz = 1'b0;
    if (!o) begin
      p  = x * y;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
      hi = a;
      lo = 32'hFFFFFFFF;
    end else begin
      qt = x / y;
      r  = x % y;
      hi = r[31:0];
      lo = qt[31:0];
    end
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return $urandom_range(0, 15);
      3: return -$urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction
  task automatic do_op(input bit o, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] eh, el;
    bit ez, tbad, hbad;
    model(o, a, b, eh, el, ez);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; A = $urandom; B = $urandom;
    tbad = (busy !== 1'b0 || done !== 1'b0);
    hbad = (Zhigh !== prev_hi || Zlow !== prev_lo);
    if (ez) begin
      @(posedge clock); #1;
      if (busy !== 1'b0 || done !== 1'b1) tbad = 1'b1;
    end else begin
      for (int i = 1; i <= 33; i++) begin
        if (i == 5) start = 1'b1;
        if (i == 6) start = 1'b0;
        @(posedge clock); #1;
        if (i <= 32 && (busy !== 1'b1 || done !== 1'b0)) tbad = 1'b1;
        if (i <= 32 && (Zhigh !== prev_hi || Zlow !== prev_lo)) hbad = 1'b1;
        if (i == 33 && (busy !== 1'b0 || done !== 1'b1)) tbad = 1'b1;
      end
    end
    checks++;
    if (tbad) begin
      errors++;
      $display("FAIL %s timing: busy=%b done=%b at end, want busy=0 done=1 after %0d edges", name, busy, done, ez ? 1 : 33);
    end
    checks++;
    if (hbad) begin
      errors++;
      $display("FAIL %s hold: Zhigh/Zlow changed before done, got %h_%h want %h_%h", name, Zhigh, Zlow, prev_hi, prev_lo);
    end
    checks++;
    if (Zhigh !== eh || Zlow !== el || div_by_zero !== ez) begin
      errors++;
      $display("FAIL %s result: op=%0b a=%h b=%h got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
               name, o, a, b, Zhigh, Zlow, div_by_zero, eh, el, ez);
    end
    prev_hi = eh;
    prev_lo = el;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (i == 0) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL idle: done=%b busy=%b want 0 0", done, busy);
        end
      end
    end
  endtask
  task automatic test_reset();
    clear = 1'b0; start = 1'b1; op = 1'b0; A = 32'd3; B = 32'd4;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || Zhigh !== 32'd0 || Zlow !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, Zhigh, Zlow);
    end
    start = 1'b0; clear = 1'b1;
    prev_hi = '0; prev_lo = '0;
    idle(2);
  endtask
  task automatic test_directed();
    do_op(1'b0, 32'd7, 32'hFFFFFFFD, "mul_7x-3");
    idle(1);
    do_op(1'b0, 32'h80000000, 32'h80000000, "mul_min_sq");
    idle(2);
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, "div_-7/2");
    idle(1);
    do_op(1'b1, 32'd5, 32'd0, "div_by_zero");
    idle(1);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    idle(1);
  endtask
  task automatic test_back_to_back();
    do_op(1'b0, 32'd12345, 32'hFFFF0001, "b2b_mul");
    do_op(1'b1, 32'd1000, 32'hFFFFFFF9, "b2b_div");
    do_op(1'b1, 32'hFFFFFFF0, 32'd0, "b2b_div0");
    do_op(1'b0, 32'hDEADBEEF, 32'h12345678, "b2b_mul2");
    idle(1);
  endtask
  task automatic test_reset_mid();
    bit saw_done;
    op = 1'b0; A = 32'd99; B = 32'd77; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    clear = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Zhigh !== 32'd0 || Zlow !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, Zhigh, Zlow);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid_quiet: done/busy seen after abort, want none");
    end
    prev_hi = '0; prev_lo = '0;
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "after_reset");
    idle(1);
  endtask
  task automatic test_random();
    logic [31:0] a, b;
    bit o;
    for (int n = 0; n < 40; n++) begin
      o = $urandom_range(0, 1);
      a = pick();
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      do_op(o, a, b, o ? "rand_div" : "rand_mul");
      idle($urandom_range(0, 2));
    end
  endtask
  initial begin
    checks = 0; errors = 0;
    start = 1'b0; op = 1'b0; A = '0; B = '0; clear = 1'b0;
    prev_hi = '0; prev_lo = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL provide the following ports (clock and reset first):
- clock  input  1 -- single clock; all state changes on its rising edge.
- clear  input  1 -- reset; synchronous, active-low.
- start  input  1 -- operation request; sampled on the clock edge.
- op  input  1 -- operation select: 0 = signed multiply, 1 = signed divide.
- A  input  32 -- operand: multiplicand or dividend (Y register value).
- B  input  32 -- operand: multiplier or divisor (BusMuxOut value).
- busy  output  1 -- operation in progress.
- done  output  1 -- one-cycle pulse; results are valid.
- div_by_zero  output  1 -- last divide had B = 0; valid with done.
- Zhigh  output  32 -- upper result word; feeds bus input BusMuxIn_Zhigh.
- Zlow  output  32 -- lower result word; feeds bus input BusMuxIn_Zlow.

REQ-002 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-003 SHALL implement the states IDLE, RUN and DONE; RUN is a 5-bit iteration counter counting 0..31.
REQ-004 SHALL accept a request on an edge where start=1 and the state is IDLE or DONE.
- Accepting latches A, B and op into internal working registers.
REQ-005 SHALL ignore start while busy=1; operands and the in-flight operation are unaffected.
REQ-006 SHALL, for an accepted request at edge k (non-zero divisor or multiply):
- busy=1 for the cycles following edges k+1..k+32 (RUN);
- done=1 for exactly the one cycle following edge k+33 (DONE);
- the state returns to IDLE at edge k+34 unless a new start is accepted on that edge.
REQ-007 Multiply SHALL compute the signed 64-bit product A*B using radix-2 Booth recoding, one iteration per RUN cycle.
- Zhigh = product[63:32]; Zlow = product[31:0].
REQ-008 Divide SHALL compute signed A/B with truncation toward zero, one quotient bit per RUN cycle.
- Magnitudes are divided non-restoring, then signs are corrected.
- Zlow = quotient; Zhigh = remainder.
- The remainder takes the sign of A and satisfies |remainder| < |B|.
REQ-009 Divide with B=0 SHALL skip RUN entirely: IDLE -> DONE at edge k+1, with done=1 in that cycle.
- busy stays 0.
- div_by_zero=1; Zlow=32'hFFFFFFFF; Zhigh=A.
REQ-010 div_by_zero SHALL be 0 for every multiply and every non-zero divide; it holds its value until the next accepted start.
REQ-011 Divide of 32'h80000000 by 32'hFFFFFFFF SHALL give Zlow=32'h80000000 and Zhigh=0, with no flag.
REQ-012 Zhigh and Zlow SHALL be registered and update only on the edge entering DONE.
- They hold the previous result throughout RUN and IDLE.
- The bus may read them at any time without glitching.
REQ-013 A start accepted in the DONE cycle SHALL begin a new operation with no idle cycle (back-to-back).
- done deasserts on that edge and busy asserts.
REQ-014 op and operand changes while busy SHALL have no effect on the result.

Reset
REQ-015 When clear=0 at an edge, the block SHALL go to IDLE with busy=0, done=0, div_by_zero=0, Zhigh=0, Zlow=0, and clear the counter and working registers.
REQ-016 Reset SHALL take priority over start on the same edge.
- Reset mid-operation aborts the operation with no done pulse.

Verification
REQ-017 Multiply: op=0, A=7, B=32'hFFFFFFFD (-3), start at edge k.
- Expect busy for 32 cycles, done at k+33, Zhigh=32'hFFFFFFFF, Zlow=32'hFFFFFFEB.
REQ-018 Multiply: op=0, A=B=32'h80000000.
- Expect Zhigh=32'h40000000, Zlow=0, div_by_zero=0.
REQ-019 Divide: op=1, A=32'hFFFFFFF9 (-7), B=2.
- Expect Zlow=32'hFFFFFFFD (-3), Zhigh=32'hFFFFFFFF (-1), done at k+33.
REQ-020 Divide by zero: op=1, A=5, B=0.
- Expect done at k+1, busy never 1, div_by_zero=1, Zlow=32'hFFFFFFFF, Zhigh=5.
REQ-021 Ignored start and back-to-back:
- Pulse start at k+5 with different operands during a multiply: expect no effect on that multiply.
- Start in the DONE cycle: expect the second result exactly 33 cycles after that edge.
REQ-022 Reset mid-operation: clear=0 at k+10 of a multiply.
- Expect busy=0, Zhigh=Zlow=0 from the next cycle, and no done pulse.
- A fresh start then completes normally.
